// File: rtl/muldiv_if.sv
// Handshake and operand bundle between the control unit and the
// HI/LO multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit. One bit per cycle on operand
// magnitudes, with signs restored in a final fix-up cycle.
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  state_t      state;
  logic [5:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] raw_a;
  logic [63:0] acc;
  logic        neg_main;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        in_signed;
  logic        a_neg;
  logic        b_neg;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Operand sign decode at accept time and one shift-add / restoring step.
  always_comb begin
    in_signed = ~bus.op[0];
    a_neg     = in_signed & bus.rs_data[31];
    b_neg     = in_signed & bus.rt_data[31];
    mul_sum   = {1'b0, acc[63:32]} + (mb[0] ? {1'b0, ma} : 33'd0);
    div_trial = {acc[63:32], ma[31]};
    div_ge    = div_trial >= {1'b0, mb};
    div_diff  = div_trial[31:0] - mb;
    prod_fix  = neg_main ? (64'd0 - acc) : acc;
    quot_fix  = neg_main ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix   = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // Control FSM, iteration datapath and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      op_q     <= OP_MULT;
      ma       <= 32'd0;
      mb       <= 32'd0;
      raw_a    <= 32'd0;
      acc      <= 64'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            busy_q   <= 1'b1;
            op_q     <= bus.op;
            ma       <= a_neg ? (32'd0 - bus.rs_data) : bus.rs_data;
            mb       <= b_neg ? (32'd0 - bus.rt_data) : bus.rt_data;
            raw_a    <= bus.rs_data;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (bus.rt_data == 32'd0);
            cnt      <= 6'd0;
            acc      <= 64'd0;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          if (op_q[1]) begin
            acc <= {(div_ge ? div_diff : div_trial[31:0]), acc[30:0], div_ge};
            ma  <= {ma[30:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[31:1]};
            mb  <= {1'b0, mb[31:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          case (op_q)
            OP_MULT:  {hi_q, lo_q} <= prod_fix;
            OP_MULTU: {hi_q, lo_q} <= acc;
            OP_DIV: begin
              hi_q <= div_zero ? raw_a : rem_fix;
              lo_q <= div_zero ? 32'hFFFF_FFFF : quot_fix;
            end
            default: begin
              hi_q <= div_zero ? raw_a : acc[63:32];
              lo_q <= div_zero ? 32'hFFFF_FFFF : acc[31:0];
            end
          endcase
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for the HI/LO multiply/divide unit.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;
  int   donePulses;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock; stimulus changes and sampling happen on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one start request for a single cycle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Counts remaining busy cycles, then checks done and the HI/LO result.
  task automatic waitDone(input string tag, input int expBusy,
                          input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(expBusy));
    checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    checkOutput({tag, "_hi"}, bus.hi, expHi);
    checkOutput({tag, "_lo"}, bus.lo, expLo);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    donePulses  = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_MULT;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.wdata   = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);

    // -3 * 7 = -21
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_busy_e0", {31'd0, bus.busy}, 32'd1);
    waitDone("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    checkOutput("mult_done_drop", {31'd0, bus.done}, 32'd0);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("mult_m1", 33, 32'h0000_0000, 32'h0000_0001);
    @(negedge clk);

    // -7 / 2 = -3 remainder -1
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);

    // Second start and an MTHI during RUN must both be ignored.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_MULTU;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd9;
    bus.mthi    = 1'b1;
    bus.wdata   = 32'hAAAA_5555;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    checkOutput("mthi_in_run", bus.hi, 32'hFFFF_FFFF);
    waitDone("divu_100_7", 27, 32'd2, 32'd14);
    @(negedge clk);

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_ovf", 33, 32'h0000_0000, 32'h8000_0000);
    @(negedge clk);

    applyStimulus(OP_DIVU, 32'h0000_1234, 32'd0);
    waitDone("divu_zero", 33, 32'h0000_1234, 32'hFFFF_FFFF);
    @(negedge clk);

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h1357_9BDF;
    @(negedge clk);
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    checkOutput("mthi_idle", bus.hi, 32'h1357_9BDF);
    checkOutput("mtlo_idle", bus.lo, 32'h1357_9BDF);

    // Back-to-back: start in the done cycle, with MTHI in the same cycle losing to start.
    applyStimulus(OP_MULTU, 32'd3, 32'd4);
    waitDone("multu_3_4", 33, 32'd0, 32'd12);
    bus.mthi  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    applyStimulus(OP_DIVU, 32'd50, 32'd8);
    bus.mthi  = 1'b0;
    checkOutput("b2b_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("start_prio_hi", bus.hi, 32'd0);
    waitDone("b2b_divu", 33, 32'd2, 32'd6);
    @(negedge clk);

    // Reset during iteration 10 of a DIV aborts with no done pulse.
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_hi", bus.hi, 32'd0);
    checkOutput("abort_lo", bus.lo, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (bus.done) donePulses++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(donePulses), 32'd0);

    applyStimulus(OP_MULT, 32'd5, 32'd6);
    waitDone("mult_5_6", 33, 32'd0, 32'd30);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
